// File: rtl/cpu_trace_tx.sv
// Commit-trace transmitter: buffers one record per retired instruction and
// streams each one out as a 20-byte checksummed frame on a valid/ready port.
module cpu_trace_tx #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_en,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_instr,
  input  logic [31:0] commit_alu,
  input  logic        commit_mr,
  input  logic        commit_mw,
  input  logic        rd_we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [15:0] drop_count,
  output logic        busy
);

  localparam int         AW    = $clog2(FIFO_DEPTH);
  localparam int         RW    = 144;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  logic [RW-1:0] mem_q [FIFO_DEPTH];
  logic [RW-1:0] rec_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    seq_q;
  logic [15:0]   drop_q;
  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;

  logic          capture, empty, full, pop, push, drop;
  logic [7:0]    flags;
  logic [RW-1:0] rec_in;
  logic [151:0]  body_w;
  logic [159:0]  frame_w;
  logic [7:0]    cs;
  logic [7:0]    frame_b [20];

  assign capture = commit_valid & trace_en;
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH);

  // A pop is the only way a record leaves the FIFO, either from IDLE or on
  // the last byte of a frame when the next record follows back to back.
  assign pop  = !empty && ((state_q == IDLE) ||
                           (state_q == SEND && tx_ready && idx_q == 5'd19));
  assign push = capture && (!full || pop);
  assign drop = capture && full && !pop;

  assign flags  = {commit_mr, commit_mw, rd_we, rd_we ? rd_addr : 5'd0};
  assign rec_in = {rd_we ? rd_data : 32'd0, commit_alu, commit_instr,
                   commit_pc, flags, seq_q};

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rec_in;
    if (pop)  rec_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (capture) seq_q <= seq_q + 8'd1;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  // Byte k of the frame sits at bits [8k+7:8k]; multi-byte fields are LE.
  assign body_w = {rec_q, SYNC_BYTE};

  always_comb begin
    cs = '0;
    for (int i = 0; i < 19; i++) cs = cs ^ body_w[i*8 +: 8];
  end

  assign frame_w = {cs, body_w};

  genvar gi;
  generate
    for (gi = 0; gi < 20; gi++) begin : g_byte
      assign frame_b[gi] = frame_w[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q == 5'd19) begin
            idx_d = '0;
            if (empty) state_d = IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign tx_valid   = (state_q == SEND);
  assign tx_data    = tx_valid ? frame_b[idx_q] : 8'd0;
  assign drop_count = drop_q;
  assign busy       = !empty || (state_q == SEND);

endmodule
